lap_recorder: RTL and testbench
===============================

Name: lap_recorder

Overview:
- Sits between the BCD stopwatch counter and the seven-segment display driver.
- Captures split/lap times from the live counter into a circular buffer.
- Selects what the display shows: the live time, a briefly held latest lap, or a recalled stored lap.
- All button inputs arrive as clean single-cycle pulses, already debounced and edge-detected in the clk domain.

Parameters:
- ADDR_W, 3, buffer address width; DEPTH = 2**ADDR_W entries (8).
- HOLD_TICKS, 30, number of tick_10hz pulses a freshly captured lap stays on display (3.0 s).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- tick_10hz  in  1  single-cycle enable at 10 Hz, synchronous to clk.
- running  in  1  stopwatch run state; 1 = counting.
- lap_pulse  in  1  single-cycle lap request.
- recall_pulse  in  1  single-cycle request to step through stored laps.
- clear_pulse  in  1  single-cycle request to empty the buffer.
- live_tens  in  4  live tens-of-seconds, BCD.
- live_ones  in  4  live seconds, BCD.
- live_tenths  in  4  live tenths, BCD.
- disp_tens  out  4  tens digit to display.
- disp_ones  out  4  ones digit to display.
- disp_tenths  out  4  tenths digit to display.
- disp_lap  out  ADDR_W+1  1-based lap number shown; 0 in LIVE.
- lap_count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- full  out  1  lap_count == DEPTH.
- mode  out  2  00 = LIVE, 01 = HOLD, 10 = RECALL.

Behaviour:
- Reset, asynchronous:
  - state LIVE; wr_ptr = 0, rd_ptr = 0, lap_count = 0, hold counter = 0.
  - all disp_* = 0, full = 0, mode = 00.
  - Buffer contents need not be cleared.
- Outputs are registered. Display values reflect inputs and state with 1 clk latency.
- Priority within one cycle: clear_pulse > lap_pulse > recall_pulse. Lower-priority pulses in the same cycle are dropped.
- Capture:
  - Condition: lap_pulse while running = 1.
  - Action: write {live_tens, live_ones, live_tenths} at wr_ptr, then wr_ptr = wr_ptr + 1 (wraps mod DEPTH).
  - lap_count increments, saturating at DEPTH.
  - When full, the new lap overwrites the oldest entry; lap_count stays at DEPTH.
  - lap_pulse with running = 0 is ignored: no write, no state change.
- A valid capture from any state enters HOLD and loads hold counter = HOLD_TICKS.
- HOLD:
  - Display shows the just-captured value; disp_lap = lap number of the newest entry = lap_count after the update.
  - Each tick_10hz decrements the hold counter.
  - On the tick where the counter reaches 0, go to LIVE.
  - A new capture during HOLD reloads the counter.
- LIVE:
  - disp_* = live_* delayed 1 clk; disp_lap = 0.
- RECALL entry:
  - recall_pulse in LIVE or HOLD with lap_count > 0 → RECALL, rd_ptr = wr_ptr - 1 (newest), disp_lap = lap_count.
  - recall_pulse with lap_count = 0 → stays LIVE.
- RECALL stepping:
  - Each recall_pulse steps to the next older entry: rd_ptr - 1 mod DEPTH, disp_lap - 1.
  - A recall_pulse while disp_lap = 1 (oldest shown) → LIVE.
  - RECALL has no timeout; tick_10hz is ignored in RECALL.
- Clear:
  - From any state: lap_count = 0, wr_ptr = 0, rd_ptr = 0, full = 0, state LIVE.
  - Effective in the same cycle as the pulse; visible on outputs next cycle.
- The counter's own reset pulse is not an input to this block. Stored laps survive a stopwatch reset; only clear_pulse or reset erases them.
- Reset asserted mid-HOLD or mid-RECALL returns to LIVE immediately, asynchronously.

Test Plan:
- Reset, then live = 1,2,3 (12.3 s) for 2 clks → mode = 00, disp = 1/2/3, disp_lap = 0, lap_count = 0.
- running = 1, live = 0/4/7, lap_pulse → next clk: mode = 01, disp = 0/4/7, disp_lap = 1; after 29 ticks still HOLD; 30th tick → mode = 00 showing live.
- 10 laps with live values 0/0/1 … 1/0/0 → lap_count = 8, full = 1; recall ×8 shows laps 10 down to 3 with disp_lap = 8..1; 9th recall → LIVE.
- running = 0, lap_pulse → no change (lap_count, mode, disp all unchanged).
- 3 laps stored, recall ×2 (disp_lap = 2), then clear_pulse + lap_pulse in the same cycle → lap_count = 0, mode = 00, no capture.
- Assert reset mid-HOLD, then release → mode = 00, disp = 0/0/0, lap_count = 0, full = 0.

Source files
------------

// File: rtl/lap_recorder.sv
// Lap/split recorder between the BCD stopwatch counter and the display driver.
// Keeps the last DEPTH laps in a circular buffer and picks the displayed time.
module lap_recorder #(
  parameter int ADDR_W     = 3,
  parameter int HOLD_TICKS = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_10hz,
  input  logic              running,
  input  logic              lap_pulse,
  input  logic              recall_pulse,
  input  logic              clear_pulse,
  input  logic [3:0]        live_tens,
  input  logic [3:0]        live_ones,
  input  logic [3:0]        live_tenths,
  output logic [3:0]        disp_tens,
  output logic [3:0]        disp_ones,
  output logic [3:0]        disp_tenths,
  output logic [ADDR_W:0]   disp_lap,
  output logic [ADDR_W:0]   lap_count,
  output logic              full,
  output logic [1:0]        mode
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    LIVE   = 2'b00,
    HOLD   = 2'b01,
    RECALL = 2'b10
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
  logic [ADDR_W-1:0] newest, older;
  logic [ADDR_W:0]   count_next, disp_lap_next;
  logic              full_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [11:0]       mem [DEPTH];
  logic [11:0]       live_word, disp_next;
  logic              wr_en;

  assign live_word = {live_tens, live_ones, live_tenths};
  assign newest    = wr_ptr - 1'b1;
  assign older     = rd_ptr - 1'b1;
  assign mode      = state;

  always_comb begin
    state_next    = state;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = lap_count;
    hold_next     = hold_cnt;
    wr_en         = 1'b0;
    disp_next     = {disp_tens, disp_ones, disp_tenths};
    disp_lap_next = disp_lap;

    if (clear_pulse) begin
      state_next  = LIVE;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      hold_next   = '0;
    end else if (lap_pulse) begin
      // A lap request while stopped is swallowed, including any recall beside it
      if (running) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr + 1'b1;
        if (lap_count != DEPTH_CNT)
          count_next = lap_count + 1'b1;
        state_next    = HOLD;
        hold_next     = HOLD_LOAD;
        disp_next     = live_word;
        disp_lap_next = count_next;
      end
    end else if (recall_pulse) begin
      case (state)
        LIVE, HOLD: begin
          if (lap_count != '0) begin
            state_next    = RECALL;
            rd_ptr_next   = newest;
            disp_next     = mem[newest];
            disp_lap_next = lap_count;
          end
        end
        RECALL: begin
          if (disp_lap == (ADDR_W + 1)'(1)) begin
            state_next = LIVE;
          end else begin
            rd_ptr_next   = older;
            disp_next     = mem[older];
            disp_lap_next = disp_lap - 1'b1;
          end
        end
        default: state_next = LIVE;
      endcase
    end else if (state == HOLD && tick_10hz) begin
      hold_next = hold_cnt - 1'b1;
      if (hold_next == '0)
        state_next = LIVE;
    end

    // LIVE always tracks the counter, whatever path led here
    if (state_next == LIVE) begin
      disp_next     = live_word;
      disp_lap_next = '0;
    end

    full_next = (count_next == DEPTH_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LIVE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      lap_count   <= '0;
      hold_cnt    <= '0;
      full        <= 1'b0;
      disp_tens   <= '0;
      disp_ones   <= '0;
      disp_tenths <= '0;
      disp_lap    <= '0;
    end else begin
      state       <= state_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      lap_count   <= count_next;
      hold_cnt    <= hold_next;
      full        <= full_next;
      disp_tens   <= disp_next[11:8];
      disp_ones   <= disp_next[7:4];
      disp_tenths <= disp_next[3:0];
      disp_lap    <= disp_lap_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= live_word;
  end

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: the driver queues expected outputs per
// cycle, the monitor compares them on the falling edge.
module tb_lap_recorder;

  logic       clk, reset, tick_10hz, running, lap_pulse, recall_pulse, clear_pulse;
  logic [3:0] live_tens, live_ones, live_tenths;
  logic [3:0] disp_tens, disp_ones, disp_tenths;
  logic [3:0] disp_lap, lap_count;
  logic       full;
  logic [1:0] mode;

  lap_recorder #(.ADDR_W(3), .HOLD_TICKS(30)) dut (
    .clk(clk), .reset(reset), .tick_10hz(tick_10hz), .running(running),
    .lap_pulse(lap_pulse), .recall_pulse(recall_pulse), .clear_pulse(clear_pulse),
    .live_tens(live_tens), .live_ones(live_ones), .live_tenths(live_tenths),
    .disp_tens(disp_tens), .disp_ones(disp_ones), .disp_tenths(disp_tenths),
    .disp_lap(disp_lap), .lap_count(lap_count), .full(full), .mode(mode)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [22:0] want;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [22:0] got;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every queued expectation is checked on the falling edge of its cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      got = {mode, disp_tens, disp_ones, disp_tenths, disp_lap, lap_count, full};
      total++;
      if (e.cyc != cyc || got !== e.want) begin
        bad++;
        $display("FAIL %s: got mode=%0d disp=%h lap=%0d cnt=%0d full=%0d, want mode=%0d disp=%h lap=%0d cnt=%0d full=%0d (cyc %0d/%0d)",
                 e.name, got[22:21], got[20:9], got[8:5], got[4:1], got[0],
                 e.want[22:21], e.want[20:9], e.want[8:5], e.want[4:1], e.want[0], cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic expect_at(input int d, input string nm, input logic [1:0] m,
                           input logic [11:0] dv, input int dl, input int lc);
    exp_t x;
    x.cyc  = cyc + d;
    x.name = nm;
    x.want = {m, dv, 4'(dl), 4'(lc), (lc == 8)};
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [11:0] v);
    {live_tens, live_ones, live_tenths} = v;
  endtask

  function automatic logic [11:0] lap_val(input int k);
    return (k < 10) ? {8'h00, 4'(k)} : 12'h100;
  endfunction

  function automatic int min8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  initial begin
    reset = 1'b1; tick_10hz = 0; running = 0;
    lap_pulse = 0; recall_pulse = 0; clear_pulse = 0;
    set_live(12'h999);
    repeat (2) @(posedge clk);
    #1;
    expect_at(0, "reset_state", 2'd0, 12'h000, 0, 0);
    step();
    reset = 1'b0;

    set_live(12'h123);
    expect_at(2, "live_123", 2'd0, 12'h123, 0, 0);
    step(); step();

    running = 1;
    set_live(12'h047);
    lap_pulse = 1;
    expect_at(1, "lap1_hold", 2'd1, 12'h047, 1, 1);
    step();
    lap_pulse = 0;
    set_live(12'h555);
    for (int i = 0; i < 29; i++) begin
      tick_10hz = 1; step();
      tick_10hz = 0; step();
    end
    expect_at(1, "hold_after_29", 2'd1, 12'h047, 1, 1);
    step();
    tick_10hz = 1;
    expect_at(1, "hold_tick_30", 2'd0, 12'h555, 0, 1);
    step();
    tick_10hz = 0;

    lap_pulse = 1;
    for (int k = 1; k <= 10; k++) begin
      set_live(lap_val(k));
      expect_at(1, $sformatf("lap_batch_%0d", k), 2'd1, lap_val(k), min8(k + 1), min8(k + 1));
      step();
    end
    lap_pulse = 0;

    set_live(12'h234);
    recall_pulse = 1;
    for (int k = 1; k <= 8; k++) begin
      expect_at(1, $sformatf("recall_%0d", k), 2'd2, lap_val(11 - k), 9 - k, 8);
      step();
    end
    expect_at(1, "recall_exit", 2'd0, 12'h234, 0, 8);
    step();
    recall_pulse = 0;

    running = 0;
    lap_pulse = 1;
    expect_at(1, "lap_stopped", 2'd0, 12'h234, 0, 8);
    step();
    lap_pulse = 0;

    clear_pulse = 1;
    expect_at(1, "clear_full", 2'd0, 12'h234, 0, 0);
    step();
    clear_pulse = 0;

    running = 1;
    lap_pulse = 1;
    for (int k = 1; k <= 3; k++) begin
      set_live(12'h111 * k);
      expect_at(1, $sformatf("lap3_%0d", k), 2'd1, 12'h111 * k, k, k);
      step();
    end
    lap_pulse = 0;
    recall_pulse = 1;
    expect_at(1, "recall3_a", 2'd2, 12'h333, 3, 3);
    step();
    expect_at(1, "recall3_b", 2'd2, 12'h222, 2, 3);
    step();
    recall_pulse = 0;
    set_live(12'h777);
    clear_pulse = 1; lap_pulse = 1;
    expect_at(1, "clear_beats_lap", 2'd0, 12'h777, 0, 0);
    step();
    clear_pulse = 0; lap_pulse = 0;
    recall_pulse = 1;
    expect_at(1, "recall_empty", 2'd0, 12'h777, 0, 0);
    step();
    recall_pulse = 0;

    set_live(12'h888);
    lap_pulse = 1;
    expect_at(1, "lap_after_clear", 2'd1, 12'h888, 1, 1);
    step();
    lap_pulse = 0;
    recall_pulse = 1;
    expect_at(1, "recall_single", 2'd2, 12'h888, 1, 1);
    step();
    expect_at(1, "recall_single_exit", 2'd0, 12'h888, 0, 1);
    step();
    recall_pulse = 0;

    set_live(12'h456);
    lap_pulse = 1;
    expect_at(1, "lap_before_reset", 2'd1, 12'h456, 2, 2);
    step();
    lap_pulse = 0;
    repeat (3) begin
      tick_10hz = 1; step();
      tick_10hz = 0; step();
    end
    #2;
    reset = 1'b1;
    #1;
    expect_at(0, "async_reset", 2'd0, 12'h000, 0, 0);
    step();
    reset = 1'b0;
    set_live(12'h666);
    expect_at(1, "after_reset", 2'd0, 12'h666, 0, 0);
    step();

    repeat (3) step();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_checks: got %0d unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
